// File: rtl/spi_master_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_scheduler_pkg
// Shared types and constants for the SPI master scheduler.
//   DATA_W   : SPI byte width
//   MODE_*   : {CKP,CPH} encodings for the four SPI modes
//   state_t  : scheduler FSM state encoding
// ---------------------------------------------------------------------------
package spi_master_scheduler_pkg;

    localparam int DATA_W = 8;

    // {CKP,CPH}
    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6,
        S_GAP     = 3'd7
    } state_t;

endpackage

// File: rtl/spi_master_scheduler_if.sv
// ---------------------------------------------------------------------------
// spi_master_scheduler_if
// Bundles the requester-side and SPI-master-side signals of the scheduler.
//   req_valid/req_data/req_mode : requester requests (per-requester slices)
//   req_ready                   : one-hot accept pulse
//   rsp_valid/rsp_id/rsp_data/rsp_err : one-cycle response strobe + payload
//   busy                        : scheduler not idle
//   spi_strt/spi_data/spi_ckp/spi_cph : to SPI master
//   spi_cs/spi_rx_data          : from SPI master
// Modports: master = the scheduler, slave = requesters + SPI master side.
// ---------------------------------------------------------------------------
interface spi_master_scheduler_if
    import spi_master_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*2-1:0]      req_mode;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    busy;
    logic                    spi_strt;
    logic [DATA_W-1:0]       spi_data;
    logic                    spi_ckp;
    logic                    spi_cph;
    logic                    spi_cs;
    logic [DATA_W-1:0]       spi_rx_data;

    modport master (
        input  req_valid, req_data, req_mode, spi_cs, spi_rx_data,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
               spi_strt, spi_data, spi_ckp, spi_cph
    );

    modport slave (
        output req_valid, req_data, req_mode, spi_cs, spi_rx_data,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
               spi_strt, spi_data, spi_ckp, spi_cph
    );

endinterface

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_scheduler_rr_arbiter
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping around.
//   i_req   : request vector
//   i_ptr   : highest-priority index this round
//   o_grant : one-hot grant (all zero if no request)
//   o_idx   : index of the granted request
//   o_any   : at least one request asserted
// ---------------------------------------------------------------------------
module spi_master_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    int              w_sum;
    logic [ID_W-1:0] w_pos;

    // Scan from the farthest position back to the pointer so the nearest
    // requester (lowest offset) is the last writer and wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = 0;
        w_pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
            w_pos = ID_W'(w_sum);
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_scheduler.sv
// ---------------------------------------------------------------------------
// spi_master_scheduler
// Shares one 8-bit SPI master between N_REQ requesters: round-robin grant,
// per-request SPI mode, start pulse, completion detected from CS, start and
// transfer timeouts, and a one-cycle response back to the granted requester.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : spi_master_scheduler_if.master (requester + SPI master signals)
// All interface outputs are registered.
// ---------------------------------------------------------------------------
module spi_master_scheduler
    import spi_master_scheduler_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int START_TO = 4,
    parameter int TIMEOUT  = 255,
    parameter int GAP      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_master_scheduler_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [DATA_W-1:0]  r_data_lat;
    logic [1:0]         r_mode_lat;
    logic [CNT_W-1:0]   r_cnt;

    logic [N_REQ-1:0]   r_req_ready;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_err;
    logic               r_busy;
    logic               r_spi_strt;
    logic [DATA_W-1:0]  r_spi_data;
    logic               r_spi_ckp;
    logic               r_spi_cph;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    spi_master_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_data_lat  <= '0;
            r_mode_lat  <= '0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_spi_strt  <= 1'b0;
            r_spi_data  <= '0;
            r_spi_ckp   <= 1'b0;
            r_spi_cph   <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_req_ready <= '0;
            r_rsp_valid <= 1'b0;
            r_spi_strt  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A low CS here is a stray transfer we do not own; hold
                    // off granting until the master is free again.
                    if (w_any && bus.spi_cs) begin
                        r_req_ready <= w_grant;
                        r_id        <= w_idx;
                        r_data_lat  <= bus.req_data[DATA_W*w_idx +: DATA_W];
                        r_mode_lat  <= bus.req_mode[2*w_idx +: 2];
                        r_ptr       <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_spi_data <= r_data_lat;
                    r_spi_ckp  <= r_mode_lat[1];
                    r_spi_cph  <= r_mode_lat[0];
                    r_state    <= S_START;
                end

                S_START: begin
                    r_spi_strt <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_WAIT_LO;
                end

                // Response registers are loaded on entry to DONE/ERR so the
                // strobe is visible while the FSM sits in that state.
                S_WAIT_LO: begin
                    if (!bus.spi_cs) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_HI;
                    end else if (r_cnt >= CNT_W'(START_TO - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_id    <= r_id;
                        r_state     <= S_ERR;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end

                S_WAIT_HI: begin
                    if (bus.spi_cs) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= bus.spi_rx_data;
                        r_rsp_id    <= r_id;
                        r_state     <= S_DONE;
                    end else if (r_cnt >= CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_id    <= r_id;
                        r_state     <= S_ERR;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end

                S_DONE, S_ERR: begin
                    r_cnt   <= '0;
                    r_state <= S_GAP;
                end

                S_GAP: begin
                    if (r_cnt >= CNT_W'(GAP - 1)) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
    assign bus.spi_strt  = r_spi_strt;
    assign bus.spi_data  = r_spi_data;
    assign bus.spi_ckp   = r_spi_ckp;
    assign bus.spi_cph   = r_spi_cph;

endmodule

// File: tb/tb_spi_master_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_master_scheduler
// Directed bench for spi_master_scheduler with a scripted SPI master model
// driving spi_cs / spi_rx_data.
// ---------------------------------------------------------------------------
module tb_spi_master_scheduler;
    import spi_master_scheduler_pkg::*;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int START_TO = 4;
    localparam int TIMEOUT  = 255;
    localparam int GAP      = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    spi_master_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    spi_master_scheduler #(
        .N_REQ    (N_REQ),
        .ID_W     (ID_W),
        .START_TO (START_TO),
        .TIMEOUT  (TIMEOUT),
        .GAP      (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, check it and the LOAD/START timing, play one SPI
    // transfer (CS low for lo_cycles) and check the response.
    task automatic do_xfer(input int exp_id, input logic [7:0] exp_tx,
                           input logic [1:0] exp_mode, input logic [7:0] rx,
                           input int lo_cycles, input int exp_wait);
        int         waited;
        bit         got;
        logic [3:0] exp_oh;
        exp_oh = 4'b0001 << exp_id;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 60) begin
            step();
            waited++;
            if (bus.req_ready !== 4'b0000) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_miss++;
            $display("FAIL grant_wait id%0d: got no req_ready in %0d cycles, required a grant", exp_id, waited);
            return;
        end
        n_vec++;
        if (bus.req_ready !== exp_oh) begin
            n_miss++;
            $display("FAIL grant_onehot: got %b required %b", bus.req_ready, exp_oh);
        end
        if (exp_wait >= 0) begin
            n_vec++;
            if (waited != exp_wait) begin
                n_miss++;
                $display("FAIL grant_latency id%0d: got %0d cycles required %0d", exp_id, waited, exp_wait);
            end
        end
        step();
        n_vec++;
        if ({bus.req_ready, bus.spi_strt} !== 5'b0) begin
            n_miss++;
            $display("FAIL ready_pulse_load: got ready=%b strt=%b required 0000/0", bus.req_ready, bus.spi_strt);
        end
        step();
        n_vec++;
        if (bus.spi_strt !== 1'b1) begin
            n_miss++;
            $display("FAIL strt_latency id%0d: got strt=%b required 1", exp_id, bus.spi_strt);
        end
        n_vec++;
        if ({bus.spi_data, bus.spi_ckp, bus.spi_cph} !== {exp_tx, exp_mode}) begin
            n_miss++;
            $display("FAIL spi_data_mode id%0d: got %h/%b%b required %h/%b", exp_id,
                     bus.spi_data, bus.spi_ckp, bus.spi_cph, exp_tx, exp_mode);
        end
        bus.spi_cs = 1'b0;
        step();
        n_vec++;
        if (bus.spi_strt !== 1'b0) begin
            n_miss++;
            $display("FAIL strt_one_cycle: got strt=%b required 0", bus.spi_strt);
        end
        repeat (lo_cycles - 1) step();
        bus.spi_rx_data = rx;
        bus.spi_cs      = 1'b1;
        step();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, ID_W'(exp_id), rx}) begin
            n_miss++;
            $display("FAIL rsp_ok: got v=%b err=%b id=%0d data=%h required v=1 err=0 id=%0d data=%h",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data, exp_id, rx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.spi_strt} !== 8'b0) begin
            n_miss++;
            $display("FAIL reset_ctrl: got ready=%b v=%b err=%b busy=%b strt=%b required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.spi_strt);
        end
        n_vec++;
        if ({bus.rsp_id, bus.rsp_data, bus.spi_data, bus.spi_ckp, bus.spi_cph} !== 20'b0) begin
            n_miss++;
            $display("FAIL reset_data: got id=%0d rsp=%h spi=%h mode=%b%b required all 0",
                     bus.rsp_id, bus.rsp_data, bus.spi_data, bus.spi_ckp, bus.spi_cph);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.req_data[7:0] = 8'hA5;
        bus.req_mode[1:0] = MODE_2;
        bus.req_valid     = 4'b0001;
        do_xfer(0, 8'hA5, MODE_2, 8'h3C, 16, 1);
        bus.req_valid = 4'b0000;
        step();
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data} !== {1'b0, 8'h3C}) begin
            n_miss++;
            $display("FAIL rsp_hold: got v=%b data=%h required v=0 data=3c", bus.rsp_valid, bus.rsp_data);
        end
        step();
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL busy_in_gap: got %b required 1", bus.busy);
        end
        step();
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL busy_after_gap: got %b required 0", bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] tx [4];
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        bus.req_data  = {tx[3], tx[2], tx[1], tx[0]};
        bus.req_mode  = {MODE_3, MODE_2, MODE_1, MODE_0};
        bus.req_valid = 4'b1111;
        // Between a response and the next grant: DONE, GAP x2, IDLE grant.
        for (int k = 0; k < 5; k++) begin
            do_xfer(k % 4, tx[k % 4], 2'(k % 4), 8'hC0 + 8'(k), 3, (k == 0) ? 1 : 4);
        end
        bus.req_valid = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_start_timeout();
        int  waited;
        bit  got;
        bus.req_valid = 4'b0010;
        got = 1'b0; waited = 0;
        while (!got && waited < 60) begin
            step(); waited++;
            if (bus.req_ready !== 4'b0000) got = 1'b1;
        end
        n_vec++;
        if (bus.req_ready !== 4'b0010) begin
            n_miss++;
            $display("FAIL st_grant: got %b required 0010", bus.req_ready);
        end
        bus.req_valid = 4'b0000;
        step(); step();
        n_vec++;
        if (bus.spi_strt !== 1'b1) begin
            n_miss++;
            $display("FAIL st_strt: got %b required 1", bus.spi_strt);
        end
        waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 20) begin
            step(); waited++;
        end
        n_vec++;
        if (waited != START_TO) begin
            n_miss++;
            $display("FAIL st_timeout_cycles: got %0d required %0d", waited, START_TO);
        end
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 2'd1, 8'h00}) begin
            n_miss++;
            $display("FAIL st_rsp: got v=%b err=%b id=%0d data=%h required v=1 err=1 id=1 data=00",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data);
        end
        repeat (3) step();
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL st_idle: got busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_xfer_timeout();
        int waited;
        int pulses;
        bus.req_valid = 4'b0100;
        waited = 0;
        while (bus.req_ready === 4'b0000 && waited < 60) begin
            step(); waited++;
        end
        n_vec++;
        if (bus.req_ready !== 4'b0100) begin
            n_miss++;
            $display("FAIL xt_grant: got %b required 0100", bus.req_ready);
        end
        bus.req_valid = 4'b0000;
        step(); step();
        bus.spi_cs = 1'b0;
        waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 400) begin
            step(); waited++;
        end
        // One cycle to see CS fall, then TIMEOUT cycles in WAIT_HI.
        n_vec++;
        if (waited != TIMEOUT + 1) begin
            n_miss++;
            $display("FAIL xt_timeout_cycles: got %0d required %0d", waited, TIMEOUT + 1);
        end
        n_vec++;
        if ({bus.rsp_err, bus.rsp_id, bus.rsp_data} !== {1'b1, 2'd2, 8'h00}) begin
            n_miss++;
            $display("FAIL xt_rsp: got err=%b id=%0d data=%h required err=1 id=2 data=00",
                     bus.rsp_err, bus.rsp_id, bus.rsp_data);
        end
        bus.req_valid = 4'b0001;
        pulses = 0;
        repeat (300 - TIMEOUT - 1) begin
            step();
            if (bus.req_ready !== 4'b0000) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_miss++;
            $display("FAIL xt_cs_low_block: got %0d grants required 0", pulses);
        end
        bus.spi_cs = 1'b1;
        do_xfer(0, 8'h11, MODE_0, 8'h5A, 2, 1);
        bus.req_valid = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        int waited;
        bus.req_valid = 4'b0100;
        waited = 0;
        while (bus.req_ready === 4'b0000 && waited < 60) begin
            step(); waited++;
        end
        bus.req_valid = 4'b0000;
        step(); step();
        bus.spi_cs = 1'b0;
        repeat (5) step();
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL rm_busy_before: got %b required 1", bus.busy);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy, bus.spi_strt, bus.rsp_valid, bus.req_ready, bus.spi_data, bus.rsp_data} !== 23'b0) begin
            n_miss++;
            $display("FAIL rm_async_clear: got busy=%b strt=%b v=%b ready=%b spi=%h rsp=%h required all 0",
                     bus.busy, bus.spi_strt, bus.rsp_valid, bus.req_ready, bus.spi_data, bus.rsp_data);
        end
        bus.spi_cs = 1'b1;
        waited = 0;
        repeat (3) begin
            step();
            if (bus.rsp_valid !== 1'b0) waited++;
        end
        n_vec++;
        if (waited != 0) begin
            n_miss++;
            $display("FAIL rm_no_rsp: got %0d strobes required 0", waited);
        end
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        do_xfer(0, 8'h11, MODE_0, 8'h77, 3, 1);
        bus.req_valid = 4'b0000;
        repeat (4) step();
    endtask

    task automatic test_ptr_wrap();
        bus.req_valid = 4'b1000;
        do_xfer(3, 8'h44, MODE_3, 8'h81, 2, 1);
        bus.req_valid = 4'b1001;
        do_xfer(0, 8'h11, MODE_0, 8'h82, 2, 4);
        do_xfer(3, 8'h44, MODE_3, 8'h83, 2, 4);
        bus.req_valid = 4'b0000;
        repeat (4) step();
    endtask

    initial begin
        n_vec           = 0;
        n_miss          = 0;
        rst             = 1'b0;
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_mode    = '0;
        bus.spi_cs      = 1'b1;
        bus.spi_rx_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_start_timeout();
        test_xfer_timeout();
        test_reset_mid();
        test_ptr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
